// File: rtl/subtractor_pkg.sv
// rtl/subtractor_pkg.sv - shared widths and FSM encodings for the serial subtractor
package subtractor_pkg;

  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A new operation may be accepted from IDLE or from DONE (back-to-back).
  function automatic logic can_accept(input logic [1:0] st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/subtractor_full.sv
// rtl/subtractor_full.sv - single-bit full subtractor cell
module subtractor_full (
  output logic diff,
  output logic outborrow,
  input  logic a,
  input  logic b,
  input  logic inborrow
);

  assign diff      = a ^ b ^ inborrow;
  assign outborrow = (~a & b) | (~(a ^ b) & inborrow);

endmodule

// File: rtl/subtractor_serial_4_bit.sv
// rtl/subtractor_serial_4_bit.sv - bit-serial 4-bit subtractor, LSB first, one bit per clock
module subtractor_serial_4_bit
  import subtractor_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic             inborrow,
  output logic [WIDTH-1:0] diff,
  output logic             outborrow,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic             borrow;
  logic             cell_d;
  logic             cell_bout;
  logic             accept;
  logic             last_bit;

  subtractor_full u_cell (
    .diff      (cell_d),
    .outborrow (cell_bout),
    .a         (a_reg[idx]),
    .b         (b_reg[idx]),
    .inborrow  (borrow)
  );

  assign accept   = start && can_accept(state);
  assign last_bit = (idx == IDX_W'(WIDTH - 1));

  // Bits accumulate in acc; diff/outborrow only change on the final bit so
  // the previous result stays visible for the whole run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      idx       <= '0;
      borrow    <= 1'b0;
      diff      <= '0;
      outborrow <= 1'b0;
    end else if (accept) begin
      state  <= ST_RUN;
      a_reg  <= num1;
      b_reg  <= num2;
      borrow <= inborrow;
      idx    <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          acc[idx] <= cell_d;
          borrow   <= cell_bout;
          idx      <= idx + IDX_W'(1);
          if (last_bit) begin
            state     <= ST_DONE;
            diff      <= {cell_d, acc[WIDTH-2:0]};
            outborrow <= cell_bout;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_subtractor_serial_4_bit.sv
// tb/tb_subtractor_serial_4_bit.sv - scoreboard bench for the serial subtractor
module tb_subtractor_serial_4_bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] num1 = '0;
  logic [3:0] num2 = '0;
  logic       inborrow = 1'b0;
  logic [3:0] diff;
  logic       outborrow;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  subtractor_serial_4_bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num1      (num1),
    .num2      (num2),
    .inborrow  (inborrow),
    .diff      (diff),
    .outborrow (outborrow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction, wrap to 4 bits, borrow when negative.
  function automatic logic [4:0] model(input logic [3:0] n1, input logic [3:0] n2, input logic bi);
    int r;
    logic [3:0] d;
    r = int'(n1) - int'(n2) - int'(bi);
    d = 4'(r);
    return {d, (r < 0)};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      logic [4:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got diff=%0d borrow=%0d with no pending request", diff, outborrow);
      end else begin
        e = exp_q.pop_front();
        if ({diff, outborrow} !== e) begin
          errors++;
          $display("FAIL result: got diff=%0d borrow=%0d expected diff=%0d borrow=%0d",
                   diff, outborrow, e[4:1], e[0]);
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] n1, input logic [3:0] n2, input logic bi,
                        output int lat, output int bcnt);
    @(negedge clk);
    num1 = n1; num2 = n2; inborrow = bi; start = 1'b1;
    exp_q.push_back(model(n1, n2, bi));
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout: no done after %0d cycles expected 5", lat);
    end
  endtask

  initial begin
    int lat, bcnt, gap;
    int order[512];

    #1;
    check("reset_diff", diff, 0);
    check("reset_borrow", outborrow, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(4'b1101, 4'b1111, 1'b0, lat, bcnt);
    check("latency", lat, 5);
    check("dir1_diff", diff, 4'b1110);
    check("dir1_borrow", outborrow, 1);

    run_op(4'b1000, 4'b0101, 1'b1, lat, bcnt);
    check("busy_cycles", bcnt, 4);
    check("dir2_diff", diff, 4'b0010);
    check("dir2_borrow", outborrow, 0);

    run_op(4'b0000, 4'b0000, 1'b1, lat, bcnt);
    check("wrap_diff", diff, 4'b1111);
    check("wrap_borrow", outborrow, 1);

    // start held high through RUN with changed operands, then re-accepted in DONE
    @(negedge clk);
    num1 = 4'd3; num2 = 4'd9; inborrow = 1'b0; start = 1'b1;
    exp_q.push_back(model(4'd3, 4'd9, 1'b0));
    @(negedge clk);
    num1 = 4'd12; num2 = 4'd4; inborrow = 1'b1;
    exp_q.push_back(model(4'd12, 4'd4, 1'b1));
    lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    check("held_first_latency", lat, 5);
    check("held_first_diff", diff, 4'd10);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    check("b2b_busy", busy, 1);
    while (!done && gap < 20) begin @(negedge clk); gap++; end
    check("b2b_gap", gap, 5);
    check("b2b_diff", diff, 4'd7);

    // asynchronous reset while bit 2 is being processed
    @(negedge clk);
    num1 = 4'd5; num2 = 4'd1; inborrow = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_diff", diff, 0);
    check("abort_borrow", outborrow, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_op(4'd9, 4'd2, 1'b1, lat, bcnt);
    check("post_reset_latency", lat, 5);
    check("post_reset_diff", diff, 4'd6);

    // every (num1, num2, inborrow) combination in shuffled order
    for (int i = 0; i < 512; i++) order[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(order[i]);
      run_op(v[8:5], v[4:1], v[0], lat, bcnt);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/subtractor_serial_4_bit.md
SUBTRACTOR_SERIAL_4_BIT -- requirements
Module: subtractor_serial_4_bit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: clk, rst.
REQ-002 Port clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous active-high reset.
REQ-004 Port start  input  1  request to begin a subtraction, sampled on rising clk.
REQ-005 Port num1  input  4  minuend, captured when start is accepted.
REQ-006 Port num2  input  4  subtrahend, captured when start is accepted.
REQ-007 Port inborrow  input  1  borrow-in into bit 0, captured when start is accepted.
REQ-008 Port diff  output  4  difference num1 - num2 - inborrow, modulo 16.
REQ-009 Port outborrow  output  1  borrow out of bit 3; high when num1 < num2 + inborrow.
REQ-010 Port busy  output  1  high while state is RUN.
REQ-011 Port done  output  1  one-cycle pulse marking diff/outborrow valid.

Function
REQ-012 The block SHALL process one bit per clock, LSB first, through one full-subtractor cell: d = a ^ b ^ bin; bout = (~a & b) | (~(a ^ b) & bin).
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> capture num1, num2, inborrow into operand/borrow registers, clear bit index to 0, go to RUN.
REQ-015 RUN: each edge writes bit[index] of the difference register, updates the borrow register, increments index.
REQ-016 RUN: on the edge processing index 3 -> go to DONE; outborrow takes the final borrow.
REQ-017 DONE: done=1 for exactly one cycle; next edge -> IDLE, or -> RUN when start=1 (back-to-back accepted).
REQ-018 Latency: start sampled at edge k -> done high in the cycle after edge k+4; busy high in the cycles after edges k to k+3.
REQ-019 start SHALL be ignored while in RUN; captured operands SHALL not change mid-operation.
REQ-020 diff and outborrow SHALL hold their last result until the next accepted start completes; intermediate bits are not valid until done.
REQ-021 Arithmetic is unsigned 4-bit; wrap-around modulo 16 with no saturation.

Reset
REQ-022 rst=1 SHALL immediately force state IDLE, diff=0, outborrow=0, busy=0, done=0, index=0, borrow register=0, regardless of clk.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse for the aborted operation.
REQ-024 After rst deasserts, the first start SHALL be accepted normally.

Structure
REQ-025 A shared package (subtractor_pkg) SHALL hold WIDTH=4, the index width (2), and the IDLE/RUN/DONE state encodings.
REQ-026 The bit cell SHALL be a separate combinational sub-module subtractor_full (diff, outborrow, a, b, inborrow), instantiated once.
REQ-027 All sequential logic SHALL be in the top module; no latches; no combinational path from inputs to outputs.

Verification
REQ-028 num1=4'b1101, num2=4'b1111, inborrow=0, start pulse -> 5 cycles later done=1, diff=4'b1110, outborrow=1.
REQ-029 num1=4'b1000, num2=4'b0101, inborrow=1 -> diff=4'b0010, outborrow=0; busy high for exactly 4 cycles.
REQ-030 num1=0, num2=0, inborrow=1 -> diff=4'b1111, outborrow=1 (full wrap-around).
REQ-031 start held high during RUN with new operands -> result reflects the first operands only; start asserted in the DONE cycle -> second result follows 4 cycles after DONE with no idle gap.
REQ-032 rst asserted asynchronously during RUN bit 2 -> outputs zero immediately, no done pulse; next start gives correct result.
REQ-033 Randomized sweep of all 512 (num1, num2, inborrow) combinations SHALL match (num1 - num2 - inborrow) mod 16 and the borrow flag.
